// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// In-order, two-lane store buffer placed in front of a dual-port data memory.
// Up to two stores per cycle are queued in a circular FIFO. Entries drain into
// whichever memory ports are not claimed by loads that cycle, oldest entry
// first. Loads receive data forwarded from the youngest matching buffered
// store. A load that only partially overlaps a buffered word raises a stall.
//
// Store handshake: o_StReady is a pure function of the registered entry count.
// When it is high, any lane whose i_StValidn is high is accepted at the next
// posedge, two stores at most. When it is low, the valids are ignored. There
// is no other flow control on the store side.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   i_StValid1/2, i_StAddr1/2,
//   i_StData1/2                    store requests; lane 1 is older
//   o_StReady                      room for two stores this cycle
//   i_LdValid1/2, i_LdAddr1/2      load requests; a valid load owns its port
//   o_LdData1/2                    forwarded data or memory read data
//   o_LdStall                      a load partially overlaps a buffered store
//   o_Address1/2, o_WriteData1/2,
//   o_WE1/2                        memory port address / write data / enable
//   i_RD1/2                        memory read data (combinational)
//   o_Empty                        no queued entries
// -----------------------------------------------------------------------------
module store_buffer #(
  parameter int D_WIDTH = 32,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_StValid1,
  input  logic               i_StValid2,
  input  logic [D_WIDTH-1:0] i_StAddr1,
  input  logic [D_WIDTH-1:0] i_StAddr2,
  input  logic [D_WIDTH-1:0] i_StData1,
  input  logic [D_WIDTH-1:0] i_StData2,
  output logic               o_StReady,
  input  logic               i_LdValid1,
  input  logic               i_LdValid2,
  input  logic [D_WIDTH-1:0] i_LdAddr1,
  input  logic [D_WIDTH-1:0] i_LdAddr2,
  output logic [D_WIDTH-1:0] o_LdData1,
  output logic [D_WIDTH-1:0] o_LdData2,
  output logic               o_LdStall,
  output logic [D_WIDTH-1:0] o_Address1,
  output logic [D_WIDTH-1:0] o_Address2,
  output logic [D_WIDTH-1:0] o_WriteData1,
  output logic [D_WIDTH-1:0] o_WriteData2,
  output logic               o_WE1,
  output logic               o_WE2,
  input  logic [D_WIDTH-1:0] i_RD1,
  input  logic [D_WIDTH-1:0] i_RD2,
  output logic               o_Empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_READY_MAX = CW'(DEPTH - 2);

  // FIFO storage and bookkeeping
  logic [D_WIDTH-1:0] addr_q [DEPTH];
  logic [D_WIDTH-1:0] data_q [DEPTH];
  logic [PW-1:0]      head_q, head_d;
  logic [PW-1:0]      tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;

  logic               st_ready;
  logic               acc1, acc2;
  logic [PW-1:0]      wr_idx2;
  logic [1:0]         n_acc, n_drain;
  logic               drain1, drain2;
  logic [PW-1:0]      drain_idx1, drain_idx2;

  // Entries listed by age: index 0 is the oldest (head).
  logic [PW-1:0]      age_idx [DEPTH];
  logic [DEPTH-1:0]   age_vld;

  logic               hit1, hit2, part1, part2;
  logic [D_WIDTH-1:0] fwd1, fwd2;

  // True when the two addresses are 1..3 bytes apart in either direction,
  // i.e. the load word straddles a buffered word without matching it.
  function automatic logic near_miss(input logic [D_WIDTH-1:0] a,
                                     input logic [D_WIDTH-1:0] b);
    logic [D_WIDTH-1:0] d_ab;
    logic [D_WIDTH-1:0] d_ba;
    d_ab = a - b;
    d_ba = b - a;
    return ((d_ab != '0) && (d_ab < D_WIDTH'(4))) ||
           ((d_ba != '0) && (d_ba < D_WIDTH'(4)));
  endfunction

  // ---------------------------------------------------------------------------
  // Enqueue: acceptance depends only on the registered count, so a store can
  // never land on an entry that is still queued, even with no drain.
  // ---------------------------------------------------------------------------
  assign st_ready = (count_q <= CNT_READY_MAX);
  assign acc1     = i_StValid1 & st_ready;
  assign acc2     = i_StValid2 & st_ready;
  // Lane 2 takes the tail slot itself when lane 1 is idle.
  assign wr_idx2  = tail_q + PW'(acc1);
  assign n_acc    = {1'b0, acc1} + {1'b0, acc2};

  // ---------------------------------------------------------------------------
  // Port allocation: a free port drains, and the oldest entry goes to the
  // lowest-numbered free port. With both ports draining, head+1 lands on
  // port 2, and port 2 wins on overlap in the memory, so program order holds.
  // ---------------------------------------------------------------------------
  always_comb begin
    drain1     = 1'b0;
    drain2     = 1'b0;
    drain_idx1 = head_q;
    drain_idx2 = head_q;
    if (!i_LdValid1 && (count_q != '0)) begin
      drain1 = 1'b1;
    end
    if (!i_LdValid2) begin
      if (drain1) begin
        if (count_q >= CW'(2)) begin
          drain2     = 1'b1;
          drain_idx2 = head_q + PW'(1);
        end
      end else if (count_q != '0) begin
        drain2 = 1'b1;
      end
    end
  end

  assign n_drain = {1'b0, drain1} + {1'b0, drain2};
  assign head_d  = head_q + PW'(n_drain);
  assign tail_d  = tail_q + PW'(n_acc);
  assign count_d = count_q + CW'(n_acc) - CW'(n_drain);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (acc1) begin
        addr_q[tail_q] <= i_StAddr1;
        data_q[tail_q] <= i_StData1;
      end
      if (acc2) begin
        addr_q[wr_idx2] <= i_StAddr2;
        data_q[wr_idx2] <= i_StData2;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Forwarding: only entries that were queued before this edge take part,
  // including ones that drain in this same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_idx[i] = head_q + PW'(i);
      age_vld[i] = (CW'(i) < count_q);
    end
  end

  // Scan from oldest to youngest so the youngest exact match wins.
  always_comb begin
    hit1  = 1'b0;
    hit2  = 1'b0;
    part1 = 1'b0;
    part2 = 1'b0;
    fwd1  = '0;
    fwd2  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (age_vld[i]) begin
        if (addr_q[age_idx[i]] == i_LdAddr1) begin
          hit1 = 1'b1;
          fwd1 = data_q[age_idx[i]];
        end else if (near_miss(i_LdAddr1, addr_q[age_idx[i]])) begin
          part1 = 1'b1;
        end
        if (addr_q[age_idx[i]] == i_LdAddr2) begin
          hit2 = 1'b1;
          fwd2 = data_q[age_idx[i]];
        end else if (near_miss(i_LdAddr2, addr_q[age_idx[i]])) begin
          part2 = 1'b1;
        end
      end
    end
  end

  // An exact match takes priority over a partial overlap with another entry.
  assign o_LdStall = (i_LdValid1 & part1 & ~hit1) | (i_LdValid2 & part2 & ~hit2);
  assign o_LdData1 = (i_LdValid1 & hit1) ? fwd1 : i_RD1;
  assign o_LdData2 = (i_LdValid2 & hit2) ? fwd2 : i_RD2;

  // ---------------------------------------------------------------------------
  // Memory port drive: a load owns its port; otherwise a drain or idle (0).
  // ---------------------------------------------------------------------------
  always_comb begin
    o_Address1   = '0;
    o_WriteData1 = '0;
    o_WE1        = 1'b0;
    o_Address2   = '0;
    o_WriteData2 = '0;
    o_WE2        = 1'b0;
    if (i_LdValid1) begin
      o_Address1 = i_LdAddr1;
    end else if (drain1) begin
      o_Address1   = addr_q[drain_idx1];
      o_WriteData1 = data_q[drain_idx1];
      o_WE1        = 1'b1;
    end
    if (i_LdValid2) begin
      o_Address2 = i_LdAddr2;
    end else if (drain2) begin
      o_Address2   = addr_q[drain_idx2];
      o_WriteData2 = data_q[drain_idx2];
      o_WE2        = 1'b1;
    end
  end

  assign o_StReady = st_ready;
  assign o_Empty   = (count_q == '0);

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
//
// Drives store_buffer against a small dual-port memory model (port 2 written
// last so it wins on the same word). Every store the bench expects to be
// accepted is pushed as {addr, data} onto exp_q; every memory write the DUT
// issues is popped and compared in order. Inputs change on the falling edge and
// outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_store_buffer;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         i_StValid1, i_StValid2;
  logic [W-1:0] i_StAddr1, i_StAddr2, i_StData1, i_StData2;
  logic         o_StReady;
  logic         i_LdValid1, i_LdValid2;
  logic [W-1:0] i_LdAddr1, i_LdAddr2;
  logic [W-1:0] o_LdData1, o_LdData2;
  logic         o_LdStall;
  logic [W-1:0] o_Address1, o_Address2, o_WriteData1, o_WriteData2;
  logic         o_WE1, o_WE2;
  logic [W-1:0] i_RD1, i_RD2;
  logic         o_Empty;

  int errors = 0;
  int checks = 0;

  logic [2*W-1:0] exp_q[$];

  // Word-addressed memory model, 256 words.
  logic [W-1:0] mem [256] = '{default: '0};

  typedef struct {
    logic         st;
    logic [W-1:0] la1;
    logic [W-1:0] la2;
    logic [W-1:0] exp_d1;
    logic [W-1:0] exp_d2;
    logic         exp_stall;
  } fwd_vec_t;

  fwd_vec_t     vecs [8];
  logic [W-1:0] drain_addr [4] = '{32'h60, 32'h64, 32'h60, 32'h70};
  logic [W-1:0] drain_data [4] = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};

  store_buffer #(.D_WIDTH(W), .DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_StValid1   (i_StValid1),
    .i_StValid2   (i_StValid2),
    .i_StAddr1    (i_StAddr1),
    .i_StAddr2    (i_StAddr2),
    .i_StData1    (i_StData1),
    .i_StData2    (i_StData2),
    .o_StReady    (o_StReady),
    .i_LdValid1   (i_LdValid1),
    .i_LdValid2   (i_LdValid2),
    .i_LdAddr1    (i_LdAddr1),
    .i_LdAddr2    (i_LdAddr2),
    .o_LdData1    (o_LdData1),
    .o_LdData2    (o_LdData2),
    .o_LdStall    (o_LdStall),
    .o_Address1   (o_Address1),
    .o_Address2   (o_Address2),
    .o_WriteData1 (o_WriteData1),
    .o_WriteData2 (o_WriteData2),
    .o_WE1        (o_WE1),
    .o_WE2        (o_WE2),
    .i_RD1        (i_RD1),
    .i_RD2        (i_RD2),
    .o_Empty      (o_Empty)
  );

  // ---------------------------------------------------------------- clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------- memory model
  assign i_RD1 = mem[o_Address1[9:2]];
  assign i_RD2 = mem[o_Address2[9:2]];

  always @(posedge clk) begin
    if (rst_n) begin
      if (o_WE1) mem[o_Address1[9:2]] <= o_WriteData1;
      if (o_WE2) mem[o_Address2[9:2]] <= o_WriteData2;
    end
  end

  // ---------------------------------------------------------------- checking
  task automatic chk(input string nm, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic sb_pop(input string nm, input logic [2*W-1:0] got);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got unexpected write %h required no write", nm, got);
    end else begin
      chk(nm, got, exp_q.pop_front());
    end
  endtask

  // Called once per cycle at the sample point: account for memory writes.
  task automatic settle();
    #1;
    if (rst_n) begin
      if (o_WE1) sb_pop("drain_p1", {o_Address1, o_WriteData1});
      if (o_WE2) sb_pop("drain_p2", {o_Address2, o_WriteData2});
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic drive_st(input logic v1, input logic [W-1:0] a1, input logic [W-1:0] d1,
                          input logic v2, input logic [W-1:0] a2, input logic [W-1:0] d2,
                          input logic expect_acc);
    i_StValid1 = v1;
    i_StAddr1  = a1;
    i_StData1  = d1;
    i_StValid2 = v2;
    i_StAddr2  = a2;
    i_StData2  = d2;
    if (expect_acc && v1) exp_q.push_back({a1, d1});
    if (expect_acc && v2) exp_q.push_back({a2, d2});
  endtask

  task automatic drive_ld(input logic v1, input logic [W-1:0] a1,
                          input logic v2, input logic [W-1:0] a2);
    i_LdValid1 = v1;
    i_LdAddr1  = a1;
    i_LdValid2 = v2;
    i_LdAddr2  = a2;
  endtask

  task automatic set_idle();
    drive_st(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    drive_ld(1'b0, '0, 1'b0, '0);
  endtask

  // ---------------------------------------------------------------- test
  initial begin
    // Forwarding table, applied with count = 4 (0x60:A1, 0x64:A2, 0x60:A3, 0x70:A4).
    vecs[0] = '{st: 1'b0, la1: 32'h60, la2: 32'h64, exp_d1: 32'hA3, exp_d2: 32'hA2, exp_stall: 1'b0};
    vecs[1] = '{st: 1'b1, la1: 32'h70, la2: 32'h80, exp_d1: 32'hA4, exp_d2: 32'h0,  exp_stall: 1'b0};
    vecs[2] = '{st: 1'b0, la1: 32'h68, la2: 32'h60, exp_d1: 32'h0,  exp_d2: 32'hA3, exp_stall: 1'b0};
    vecs[3] = '{st: 1'b1, la1: 32'h62, la2: 32'h64, exp_d1: 32'h0,  exp_d2: 32'hA2, exp_stall: 1'b1};
    vecs[4] = '{st: 1'b0, la1: 32'h6D, la2: 32'h100, exp_d1: 32'h0, exp_d2: 32'h0,  exp_stall: 1'b1};
    vecs[5] = '{st: 1'b1, la1: 32'h73, la2: 32'h30, exp_d1: 32'h0,  exp_d2: 32'h6,  exp_stall: 1'b1};
    vecs[6] = '{st: 1'b0, la1: 32'h74, la2: 32'h5C, exp_d1: 32'h0,  exp_d2: 32'h0,  exp_stall: 1'b0};
    vecs[7] = '{st: 1'b0, la1: 32'h40, la2: 32'h10, exp_d1: 32'h22222222, exp_d2: 32'hAAAA0001, exp_stall: 1'b0};

    rst_n = 1'b0;
    set_idle();
    repeat (2) @(negedge clk);
    settle();
    chk("reset_empty",   64'(o_Empty),   64'(1));
    chk("reset_ready",   64'(o_StReady), 64'(1));
    chk("reset_we",      64'({o_WE1, o_WE2}), 64'(0));
    chk("reset_stall",   64'(o_LdStall), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Dual enqueue then dual drain.
    drive_st(1'b1, 32'h10, 32'hAAAA0001, 1'b1, 32'h20, 32'hBBBB0002, 1'b1);
    settle();
    chk("dual_c0_we", 64'({o_WE1, o_WE2}), 64'(0));
    @(negedge clk);
    set_idle();
    settle();
    chk("dual_c1_we",    64'({o_WE1, o_WE2}), 64'(2'b11));
    chk("dual_c1_addr1", 64'(o_Address1), 64'(32'h10));
    chk("dual_c1_addr2", 64'(o_Address2), 64'(32'h20));
    @(negedge clk);
    settle();
    chk("dual_c2_empty", 64'(o_Empty), 64'(1));
    chk("dual_mem10",    64'(mem[32'h10 >> 2]), 64'(32'hAAAA0001));
    @(negedge clk);

    // Same-address ordering: the younger lane-2 store must end in memory.
    drive_st(1'b1, 32'h40, 32'h11111111, 1'b1, 32'h40, 32'h22222222, 1'b1);
    settle();
    @(negedge clk);
    set_idle();
    settle();
    @(negedge clk);
    settle();
    chk("order_mem40", 64'(mem[32'h40 >> 2]), 64'(32'h22222222));
    @(negedge clk);

    // Lane 2 alone takes the tail slot and drains through port 1.
    drive_st(1'b0, '0, '0, 1'b1, 32'h44, 32'h77, 1'b1);
    settle();
    @(negedge clk);
    set_idle();
    settle();
    chk("lane2_we",   64'({o_WE1, o_WE2}), 64'(2'b10));
    chk("lane2_addr", 64'(o_Address1), 64'(32'h44));
    @(negedge clk);

    // Forwarding with port 2 free.
    drive_st(1'b1, 32'h30, 32'h5, 1'b1, 32'h30, 32'h6, 1'b1);
    drive_ld(1'b1, 32'h200, 1'b1, 32'h204);
    settle();
    @(negedge clk);
    drive_st(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    drive_ld(1'b1, 32'h30, 1'b0, '0);
    settle();
    chk("fwd_data1", 64'(o_LdData1), 64'(32'h6));
    chk("fwd_stall", 64'(o_LdStall), 64'(0));
    chk("fwd_we",    64'({o_WE1, o_WE2}), 64'(2'b01));
    chk("fwd_wd2",   64'(o_WriteData2), 64'(32'h5));
    @(negedge clk);
    set_idle();
    settle();
    @(negedge clk);

    // Partial overlap stalls; dropping the loads lets the store drain.
    drive_st(1'b1, 32'h50, 32'hC0DE, 1'b0, '0, '0, 1'b1);
    drive_ld(1'b1, 32'h200, 1'b1, 32'h204);
    settle();
    @(negedge clk);
    drive_st(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    drive_ld(1'b1, 32'h52, 1'b1, 32'h204);
    settle();
    chk("part_stall", 64'(o_LdStall), 64'(1));
    chk("part_we",    64'({o_WE1, o_WE2}), 64'(0));
    @(negedge clk);
    drive_ld(1'b0, '0, 1'b0, '0);
    settle();
    chk("part_drain_we", 64'({o_WE1, o_WE2}), 64'(2'b10));
    @(negedge clk);
    drive_ld(1'b1, 32'h52, 1'b0, '0);
    settle();
    chk("part_reissue_data",  64'(o_LdData1), 64'(32'hC0DE));
    chk("part_reissue_stall", 64'(o_LdStall), 64'(0));
    @(negedge clk);

    // Fill to DEPTH with both load ports busy.
    drive_st(1'b1, 32'h60, 32'hA1, 1'b1, 32'h64, 32'hA2, 1'b1);
    drive_ld(1'b1, 32'h200, 1'b1, 32'h204);
    settle();
    chk("fill_ready0", 64'(o_StReady), 64'(1));
    @(negedge clk);
    drive_st(1'b1, 32'h60, 32'hA3, 1'b1, 32'h70, 32'hA4, 1'b1);
    settle();
    chk("fill_ready2", 64'(o_StReady), 64'(1));
    @(negedge clk);

    // Table: forwarding / stall with a full buffer; offered stores are ignored.
    for (int i = 0; i < 8; i++) begin
      drive_st(vecs[i].st, 32'h90, 32'hDEAD0000 + 32'(i), vecs[i].st, 32'h94, 32'hBEEF0000 + 32'(i), 1'b0);
      drive_ld(1'b1, vecs[i].la1, 1'b1, vecs[i].la2);
      settle();
      chk($sformatf("vec%0d_d1", i),    64'(o_LdData1), 64'(vecs[i].exp_d1));
      chk($sformatf("vec%0d_d2", i),    64'(o_LdData2), 64'(vecs[i].exp_d2));
      chk($sformatf("vec%0d_stall", i), 64'(o_LdStall), 64'(vecs[i].exp_stall));
      chk($sformatf("vec%0d_ready", i), 64'(o_StReady), 64'(0));
      chk($sformatf("vec%0d_we", i),    64'({o_WE1, o_WE2}), 64'(0));
      @(negedge clk);
    end

    // Release port 2 only: one entry per cycle through o_WE2, in order.
    drive_st(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    drive_ld(1'b1, 32'h200, 1'b0, '0);
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("full_drain%0d_we", k),    64'({o_WE1, o_WE2}), 64'(2'b01));
      chk($sformatf("full_drain%0d_addr", k),  64'(o_Address2), 64'(drain_addr[k]));
      chk($sformatf("full_drain%0d_data", k),  64'(o_WriteData2), 64'(drain_data[k]));
      chk($sformatf("full_drain%0d_ready", k), 64'(o_StReady), 64'((4 - k) <= 2));
      @(negedge clk);
    end
    settle();
    chk("full_empty", 64'(o_Empty), 64'(1));
    chk("full_we",    64'({o_WE1, o_WE2}), 64'(0));
    @(negedge clk);

    // Reset mid-stream with three entries queued.
    drive_st(1'b1, 32'h80, 32'h1, 1'b1, 32'h84, 32'h2, 1'b1);
    drive_ld(1'b1, 32'h200, 1'b1, 32'h204);
    settle();
    @(negedge clk);
    drive_st(1'b0, '0, '0, 1'b1, 32'h88, 32'h3, 1'b1);
    settle();
    @(negedge clk);
    drive_st(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    settle();
    chk("pre_reset_empty", 64'(o_Empty), 64'(0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_empty", 64'(o_Empty), 64'(1));
    chk("mid_reset_we",    64'({o_WE1, o_WE2}), 64'(0));
    chk("mid_reset_ready", 64'(o_StReady), 64'(1));
    exp_q.delete();
    @(negedge clk);
    set_idle();
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      settle();
    end
    chk("post_reset_empty", 64'(o_Empty), 64'(1));
    chk("post_reset_mem80", 64'(mem[32'h80 >> 2]), 64'(0));
    chk("post_reset_mem84", 64'(mem[32'h84 >> 2]), 64'(0));
    chk("post_reset_mem88", 64'(mem[32'h88 >> 2]), 64'(0));
    @(negedge clk);

    // Random traffic: stores only while ready, loads in a disjoint region.
    for (int c = 0; c < 60; c++) begin
      logic sv1;
      logic sv2;
      sv1 = o_StReady & 1'($urandom_range(0, 1));
      sv2 = o_StReady & 1'($urandom_range(0, 1));
      drive_st(sv1, 32'h100 + 32'($urandom_range(0, 63)) * 4, $urandom,
               sv2, 32'h100 + 32'($urandom_range(0, 63)) * 4, $urandom, 1'b1);
      drive_ld(1'($urandom_range(0, 1)), 32'h300 + 32'($urandom_range(0, 15)) * 4,
               1'($urandom_range(0, 1)), 32'h340 + 32'($urandom_range(0, 15)) * 4);
      settle();
      @(negedge clk);
    end
    set_idle();
    for (int k = 0; k < 20; k++) begin
      settle();
      if (o_Empty) break;
      @(negedge clk);
    end
    chk("rand_drained",  64'(o_Empty), 64'(1));
    chk("sb_queue_left", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
